// File: rtl/ecg_decoder.sv
// ecg_decoder: serial MSB-first ECG packet decoder with sign/magnitude sample reconstruction.
// Optional macro UNDERFLOW_PREVENTION_EN adds an underflow_prevention bit, stuffing count and stuffing bits.
module ecg_decoder #(
    parameter int Data_width = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic                         bit_ready,
    output logic signed [Data_width-1:0] sample_1,
    output logic signed [Data_width-1:0] sample_2,
    output logic signed [Data_width-1:0] sample_3,
    output logic signed [Data_width-1:0] sample_4,
    output logic [1:0]                   ecgidx,
    output logic [1:0]                   sub_sample_info,
    output logic [1:0]                   component_idx,
    output logic                         component_skip,
    output logic                         valid_op,
    input  logic                         out_ready,
    output logic                         stuff_err
);
    typedef enum logic [2:0] {HDR, STUFF_CNT, STUFF, SIGN, MAG, OUT} state_t;
    state_t state;
    logic [7:0] cnt;
    logic [1:0] idx;
    logic sign;
    logic [7:0] mag;
    logic run;
    logic signed [Data_width-1:0] s [4];
    logic [7:0] last_mag;
    logic [Data_width-1:0] mag_ext;
    logic [Data_width-1:0] rec;
`ifdef UNDERFLOW_PREVENTION_EN
    logic [7:0] stuff_c;
    logic [7:0] stuff_next;
    assign stuff_next = {stuff_c[6:0], bit_in};
`else
    assign stuff_err = 1'b0;
`endif
    assign last_mag = {5'd0, sub_sample_info, 1'b0} + 8'd2;
    assign mag_ext = {{(Data_width-9){1'b0}}, mag, bit_in};
    assign rec = sign ? -mag_ext : mag_ext;
    assign valid_op = state == OUT;
    assign bit_ready = run && state != OUT;
    assign sample_1 = s[0];
    assign sample_2 = s[1];
    assign sample_3 = s[2];
    assign sample_4 = s[3];
    // packet FSM: header capture, optional stuffing, sample assembly, output hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HDR;
            cnt <= '0;
            idx <= '0;
            sign <= 1'b0;
            mag <= '0;
            run <= 1'b0;
            s <= '{default: '0};
            ecgidx <= '0;
            sub_sample_info <= '0;
            component_idx <= '0;
            component_skip <= 1'b0;
`ifdef UNDERFLOW_PREVENTION_EN
            stuff_c <= '0;
            stuff_err <= 1'b0;
`endif
        end else begin
            run <= 1'b1;
`ifdef UNDERFLOW_PREVENTION_EN
            stuff_err <= 1'b0;
`endif
            if (state == OUT) begin
                if (out_ready) state <= HDR;
            end else if (bit_valid && bit_ready) begin
                case (state)
                    HDR: begin
                        cnt <= cnt + 8'd1;
                        case (cnt[2:0])
                            3'd0: ecgidx[1] <= bit_in;
                            3'd1: ecgidx[0] <= bit_in;
                            3'd2: sub_sample_info[1] <= bit_in;
                            3'd3: sub_sample_info[0] <= bit_in;
                            3'd4: component_idx[1] <= bit_in;
                            3'd5: component_idx[0] <= bit_in;
                            default: ;
                        endcase
                        if (cnt == 8'd6) begin
                            component_skip <= bit_in;
                            if (bit_in) s <= '{default: '0};
                        end
`ifdef UNDERFLOW_PREVENTION_EN
                        if (cnt == 8'd7) begin
                            cnt <= '0;
                            state <= bit_in ? STUFF_CNT : component_skip ? OUT : SIGN;
                        end
`else
                        if (cnt == 8'd6) begin
                            cnt <= '0;
                            state <= bit_in ? OUT : SIGN;
                        end
`endif
                    end
`ifdef UNDERFLOW_PREVENTION_EN
                    STUFF_CNT: begin
                        cnt <= cnt + 8'd1;
                        stuff_c <= stuff_next;
                        if (cnt == 8'd7) begin
                            cnt <= '0;
                            state <= stuff_next != 8'd0 ? STUFF : component_skip ? OUT : SIGN;
                        end
                    end
                    STUFF: begin
                        cnt <= cnt + 8'd1;
                        stuff_err <= bit_in;
                        if (cnt == stuff_c - 8'd1) begin
                            cnt <= '0;
                            state <= component_skip ? OUT : SIGN;
                        end
                    end
`endif
                    SIGN: begin
                        sign <= bit_in;
                        mag <= '0;
                        state <= MAG;
                    end
                    MAG: begin
                        cnt <= cnt + 8'd1;
                        mag <= {mag[6:0], bit_in};
                        if (cnt == last_mag) begin
                            cnt <= '0;
                            s[idx] <= rec;
                            idx <= idx + 2'd1;
                            state <= idx == 2'd3 ? OUT : SIGN;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ecg_decoder.sv
// tb_ecg_decoder: directed packets checked against a bit-stream parsing model of the packet format.
module tb_ecg_decoder;
    localparam int DW = 10;
    logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b0;
    logic bit_ready, component_skip, valid_op, stuff_err;
    logic signed [DW-1:0] sample_1, sample_2, sample_3, sample_4;
    logic [1:0] ecgidx, sub_sample_info, component_idx;
    int total = 0, fails = 0, errs_seen = 0, e0 = 0;
    bit started = 1'b0;
    bit pk[$];
    int exp_e, exp_ssi, exp_ci, exp_sk, exp_errs;
    int exp_s[4];

    ecg_decoder #(.Data_width(DW)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sample_1(sample_1), .sample_2(sample_2), .sample_3(sample_3), .sample_4(sample_4),
        .ecgidx(ecgidx), .sub_sample_info(sub_sample_info), .component_idx(component_idx),
        .component_skip(component_skip), .valid_op(valid_op), .out_ready(out_ready), .stuff_err(stuff_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic push(input int v, input int n);
        for (int i = n - 1; i >= 0; i--) pk.push_back(v[i]);
    endtask

    task automatic push_hdr(input int e, input int ssi, input int ci, input int sk, input int up);
        push(e, 2); push(ssi, 2); push(ci, 2); push(sk, 1);
`ifdef UNDERFLOW_PREVENTION_EN
        push(up, 1);
`endif
    endtask

    task automatic push_s(input int v, input int w);
        push(v < 0 ? 1 : 0, 1);
        push(v < 0 ? -v : v, w);
    endtask

    function automatic int field(input int p, input int n);
        int v = 0;
        for (int i = 0; i < n; i++) v = v * 2 + int'(pk[p + i]);
        return v;
    endfunction

    // parse the queued bit stream into the fields a consumer must see
    task automatic model();
        int p, c, w, m;
        exp_e = field(0, 2); exp_ssi = field(2, 2); exp_ci = field(4, 2); exp_sk = int'(pk[6]);
        exp_errs = 0;
        p = 7;
`ifdef UNDERFLOW_PREVENTION_EN
        p = 8;
        if (pk[7]) begin
            c = field(8, 8);
            p = 16;
            for (int i = 0; i < c; i++) exp_errs += int'(pk[p + i]);
            p += c;
        end
`endif
        for (int k = 0; k < 4; k++) begin
            exp_s[k] = 0;
            if (exp_sk == 0) begin
                w = 3 + 2 * exp_ssi;
                m = field(p + 1, w);
                exp_s[k] = pk[p] ? -m : m;
                p += 1 + w;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_op) begin
            chk("ecgidx", ecgidx, exp_e);
            chk("sub_sample_info", sub_sample_info, exp_ssi);
            chk("component_idx", component_idx, exp_ci);
            chk("component_skip", component_skip, exp_sk);
            chk("sample_1", sample_1, exp_s[0]);
            chk("sample_2", sample_2, exp_s[1]);
            chk("sample_3", sample_3, exp_s[2]);
            chk("sample_4", sample_4, exp_s[3]);
        end
        if (!rst && started) chk("bit_ready_vs_valid", bit_ready, !valid_op);
        if (stuff_err) errs_seen++;
`ifndef UNDERFLOW_PREVENTION_EN
        chk("stuff_err_tied", stuff_err, 0);
`endif
    end

    task automatic send_bit(input bit b);
        bit ok;
        int n = 0;
        bit_valid = 1'b1;
        bit_in = b;
        forever begin
            ok = bit_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (++n > 50) begin
                total++; fails++;
                $display("FAIL accept_timeout: bit not taken within 50 cycles");
                break;
            end
        end
    endtask

    task automatic send_pkt(input int gap);
        model();
        foreach (pk[i]) begin
            if (gap > 0 && i % gap == gap - 1) begin
                bit_valid = 1'b0;
                bit_in = 1'b1;
                repeat (2) @(posedge clk);
                #1;
            end
            send_bit(pk[i]);
        end
        bit_valid = 1'b0;
        @(negedge clk);
        chk("valid_after_last_bit", valid_op, 1);
    endtask

    task automatic release_out();
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("valid_fall", valid_op, 0);
        chk("ready_rise", bit_ready, 1);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_ecgidx"}, ecgidx, 0);
        chk({n, "_ssi"}, sub_sample_info, 0);
        chk({n, "_cidx"}, component_idx, 0);
        chk({n, "_skip"}, component_skip, 0);
        chk({n, "_s1"}, sample_1, 0);
        chk({n, "_s2"}, sample_2, 0);
        chk({n, "_s3"}, sample_3, 0);
        chk({n, "_s4"}, sample_4, 0);
        chk({n, "_valid"}, valid_op, 0);
        chk({n, "_ready"}, bit_ready, 0);
        chk({n, "_stuff_err"}, stuff_err, 0);
    endtask

    task automatic chk_base(input string n);
        chk({n, "_ecgidx"}, ecgidx, 1);
        chk({n, "_ssi"}, sub_sample_info, 0);
        chk({n, "_cidx"}, component_idx, 2);
        chk({n, "_skip"}, component_skip, 0);
        chk({n, "_s1"}, sample_1, 3);
        chk({n, "_s2"}, sample_2, -5);
        chk({n, "_s3"}, sample_3, 0);
        chk({n, "_s4"}, sample_4, 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        #1 rst = 1'b0;
        @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bit_ready, 1);

        pk = {}; push_hdr(1, 0, 2, 0, 0); push('h3D07, 16);
        chk("base_len", pk.size() - (pk.size() > 23 ? 1 : 0), 23);
        send_pkt(0);
        chk_base("base");
        release_out();

        pk = {}; push_hdr(3, 1, 0, 1, 0);
        send_pkt(0);
        chk("skip_flag", component_skip, 1);
        chk("skip_ecgidx", ecgidx, 3);
        chk("skip_s1", sample_1, 0);
        chk("skip_s4", sample_4, 0);
        release_out();

        pk = {}; push_hdr(0, 3, 1, 0, 0);
        push_s(-511, 9); push_s(511, 9); push_s(1, 9); push_s(-1, 9);
        send_pkt(3);
        chk("wide_raw1", int'($unsigned(sample_1)), 'h201);
        chk("wide_raw2", int'($unsigned(sample_2)), 'h1FF);
        chk("wide_raw3", int'($unsigned(sample_3)), 'h001);
        chk("wide_raw4", int'($unsigned(sample_4)), 'h3FF);
        release_out();

        pk = {}; push_hdr(2, 1, 3, 0, 0);
        push_s(-31, 5); push_s(17, 5); push_s(0, 5); push_s(-1, 5);
        send_pkt(0);
        bit_valid = 1'b1;
        bit_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready_low", bit_ready, 0);
            chk("bp_valid_held", valid_op, 1);
            chk("bp_s1_held", sample_1, -31);
        end
        release_out();
        pk = {}; push_hdr(2, 2, 0, 0, 0);
        push_s(100, 7); push_s(-127, 7); push_s(64, 7); push_s(-3, 7);
        send_pkt(4);
        chk("bp_b_s2", sample_2, -127);
        chk("bp_b_ssi", sub_sample_info, 2);
        release_out();

        pk = {}; push_hdr(1, 0, 2, 0, 0); push('h3D07, 16);
        for (int i = 0; i < 10; i++) send_bit(pk[i]);
        bit_valid = 1'b0;
        started = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 started = 1'b1;
        send_pkt(0);
        chk_base("after_reset");
        release_out();

`ifdef UNDERFLOW_PREVENTION_EN
        pk = {}; push_hdr(1, 0, 2, 0, 1); push(3, 8); push(2, 3); push('h3D07, 16);
        e0 = errs_seen;
        send_pkt(0);
        chk("model_stuff_errs", exp_errs, 1);
        chk("stuff_pulses", errs_seen - e0, 1);
        chk_base("stuffed");
        release_out();
        pk = {}; push_hdr(2, 0, 1, 1, 1); push(0, 8);
        e0 = errs_seen;
        send_pkt(0);
        chk("zero_c_skip", component_skip, 1);
        chk("zero_c_pulses", errs_seen - e0, 0);
        release_out();
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
